// File: rtl/mem_access_controller.sv
// Arbiter and sequencer for the shared instruction/data memory port.
// Fetch and load/store requests share one address/write port; stores below ADDRESS are rejected.
module mem_access_controller #(
    parameter int ADDRESS     = 80,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_MemWrite,
    input  logic [31:0]       mem_readData,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       grant_data;
    logic       last_grant_data;
    logic       op_we;
    logic       op_fault;
    logic [1:0] lat_cnt;

    logic any_req;
    logic pick_data;
    logic store_fault;

    // On a tie the data port wins only if fetch was the previous tie winner.
    assign any_req     = if_req || d_req;
    assign pick_data   = d_req && (!if_req || !last_grant_data);
    assign store_fault = pick_data && d_we && (d_addr < ADDR_W'(ADDRESS));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = store_fault ? RESP : ISSUE;
                end
            end
            ISSUE:   state_next = op_we ? RESP : WAIT;
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            grant_data      <= 1'b0;
            last_grant_data <= 1'b1;
            op_we           <= 1'b0;
            op_fault        <= 1'b0;
            lat_cnt         <= 2'd0;
            mem_address     <= '0;
            mem_writeData   <= '0;
            if_rdata        <= '0;
            d_rdata         <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_data <= pick_data;
                        op_we      <= pick_data && d_we;
                        op_fault   <= store_fault;
                        if (if_req && d_req) begin
                            last_grant_data <= pick_data;
                        end
                        // A rejected store never touches the memory port.
                        if (!store_fault) begin
                            mem_address <= pick_data ? d_addr : if_addr;
                            if (pick_data && d_we) begin
                                mem_writeData <= d_wdata;
                            end
                        end
                    end
                end
                ISSUE: lat_cnt <= LAT_INIT;
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        if (grant_data) begin
                            d_rdata <= mem_readData;
                        end else begin
                            if_rdata <= mem_readData;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_MemWrite = (state == ISSUE) && op_we;
    assign if_ack       = (state == RESP) && !grant_data;
    assign d_ack        = (state == RESP) && grant_data;
    assign d_fault      = (state == RESP) && grant_data && op_fault;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: one latency-1 and one latency-3 instance,
// each with a small block-RAM model whose read pipeline depth equals its latency.
module tb_mem_access_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic init_mem;
    int   total = 0;
    int   bad   = 0;

    // latency-1 instance
    logic        if_req, d_req, d_we;
    logic [9:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_ack, d_ack, d_fault, mem_MemWrite, busy;
    logic [31:0] if_rdata, d_rdata, mem_writeData, mem_readData;
    logic [9:0]  mem_address;

    // latency-3 instance
    logic        l3_if_req, l3_d_req, l3_d_we;
    logic [9:0]  l3_if_addr, l3_d_addr;
    logic [31:0] l3_d_wdata;
    logic        l3_if_ack, l3_d_ack, l3_d_fault, l3_mem_MemWrite, l3_busy;
    logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_writeData, l3_mem_readData;
    logic [9:0]  l3_mem_address;

    mem_access_controller #(.ADDRESS(80), .ADDR_W(10), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_fault(d_fault),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemWrite(mem_MemWrite), .mem_readData(mem_readData), .busy(busy)
    );

    mem_access_controller #(.ADDRESS(80), .ADDR_W(10), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack), .if_rdata(l3_if_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_ack(l3_d_ack), .d_rdata(l3_d_rdata), .d_fault(l3_d_fault),
        .mem_address(l3_mem_address), .mem_writeData(l3_mem_writeData),
        .mem_MemWrite(l3_mem_MemWrite), .mem_readData(l3_mem_readData), .busy(l3_busy)
    );

    logic [31:0] mem1 [0:255];
    logic [31:0] p1;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
            mem1[0]  <= 32'h20080005;
            mem1[1]  <= 32'h0BADF00D;
            mem1[2]  <= 32'h77777777;
            mem1[3]  <= 32'h0C0FFEE0;
            mem1[4]  <= 32'h0000AAAA;
            mem1[22] <= 32'h5A5A5A5A;
        end else if (mem_MemWrite) begin
            mem1[mem_address[9:2]] <= mem_writeData;
        end
        p1 <= mem1[mem_address[9:2]];
    end
    assign mem_readData = p1;

    logic [31:0] mem3 [0:255];
    logic [31:0] q0, q1, q2;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'h0;
            mem3[0]  <= 32'h11111111;
            mem3[25] <= 32'hCAFEF00D;
        end else if (l3_mem_MemWrite) begin
            mem3[l3_mem_address[9:2]] <= l3_mem_writeData;
        end
        q0 <= mem3[l3_mem_address[9:2]];
        q1 <= q0;
        q2 <= q1;
    end
    assign l3_mem_readData = q2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        l3_if_req = 0; l3_if_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0; l3_d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1; init_mem = 1;
        idle_inputs();
        step(); step();
        init_mem = 0;
        total++;
        if ({if_ack, d_ack, d_fault, mem_MemWrite, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {if_ack, d_ack, d_fault, mem_MemWrite, busy});
        end
        total++;
        if ({if_rdata, d_rdata, mem_writeData, mem_address} !== 106'b0) begin
            bad++; $display("FAIL reset_data got if_rdata=%h d_rdata=%h wd=%h addr=%h want all 0",
                            if_rdata, d_rdata, mem_writeData, mem_address);
        end
        reset = 0;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 10'h000;
        step();
        total++;
        if (busy !== 1'b1 || if_ack !== 1'b0) begin
            bad++; $display("FAIL fetch_t1 busy=%b if_ack=%b want busy=1 ack=0", busy, if_ack);
        end
        step();
        total++;
        if (busy !== 1'b1 || if_ack !== 1'b0) begin
            bad++; $display("FAIL fetch_t2 busy=%b if_ack=%b want busy=1 ack=0", busy, if_ack);
        end
        step();
        total++;
        if (busy !== 1'b1 || if_ack !== 1'b1 || if_rdata !== 32'h20080005) begin
            bad++; $display("FAIL fetch_t3 busy=%b if_ack=%b rdata=%h want 1 1 20080005", busy, if_ack, if_rdata);
        end
        if_req = 0;
        step();
        total++;
        if (busy !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h20080005) begin
            bad++; $display("FAIL fetch_t4 busy=%b if_ack=%b rdata=%h want 0 0 20080005", busy, if_ack, if_rdata);
        end
    endtask

    task automatic test_store_load();
        d_req = 1; d_we = 1; d_addr = 10'h054; d_wdata = 32'hDEADBEEF;
        step();
        total++;
        if (mem_MemWrite !== 1'b1 || mem_address !== 10'h054 || mem_writeData !== 32'hDEADBEEF || d_ack !== 1'b0) begin
            bad++; $display("FAIL store_t1 we=%b addr=%h wd=%h ack=%b want 1 054 deadbeef 0",
                            mem_MemWrite, mem_address, mem_writeData, d_ack);
        end
        step();
        total++;
        if (mem_MemWrite !== 1'b0 || d_ack !== 1'b1 || d_fault !== 1'b0) begin
            bad++; $display("FAIL store_t2 we=%b ack=%b fault=%b want 0 1 0", mem_MemWrite, d_ack, d_fault);
        end
        d_req = 0; d_we = 0;
        step();
        d_req = 1;
        step();
        total++;
        if (mem_MemWrite !== 1'b0 || mem_address !== 10'h054) begin
            bad++; $display("FAIL load_t1 we=%b addr=%h want 0 054", mem_MemWrite, mem_address);
        end
        step();
        step();
        total++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF || d_fault !== 1'b0) begin
            bad++; $display("FAIL load_t3 ack=%b rdata=%h fault=%b want 1 deadbeef 0", d_ack, d_rdata, d_fault);
        end
        d_req = 0;
        step();
    endtask

    task automatic test_protected_store();
        d_req = 1; d_we = 1; d_addr = 10'h010; d_wdata = 32'h12345678;
        step();
        total++;
        if (d_ack !== 1'b1 || d_fault !== 1'b1 || mem_MemWrite !== 1'b0) begin
            bad++; $display("FAIL prot_t1 ack=%b fault=%b we=%b want 1 1 0", d_ack, d_fault, mem_MemWrite);
        end
        d_req = 0; d_we = 0;
        step();
        total++;
        if (d_ack !== 1'b0 || d_fault !== 1'b0 || mem_MemWrite !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL prot_t2 ack=%b fault=%b we=%b busy=%b want 0 0 0 0", d_ack, d_fault, mem_MemWrite, busy);
        end
        total++;
        if (mem1[4] !== 32'h0000AAAA) begin
            bad++; $display("FAIL prot_mem got=%h want=0000aaaa", mem1[4]);
        end
    endtask

    task automatic test_contention();
        string order;
        int    both;
        order = "";
        both = 0;
        reset = 1;
        if_req = 1; if_addr = 10'h004; d_req = 1; d_we = 0; d_addr = 10'h058;
        step();
        reset = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (if_ack && d_ack) both++;
            if (if_ack) begin
                order = {order, "F"};
                total++;
                if (if_rdata !== 32'h0BADF00D) begin
                    bad++; $display("FAIL cont_if_rdata got=%h want=0badf00d", if_rdata);
                end
            end
            if (d_ack) begin
                order = {order, "D"};
                total++;
                if (d_rdata !== 32'h5A5A5A5A) begin
                    bad++; $display("FAIL cont_d_rdata got=%h want=5a5a5a5a", d_rdata);
                end
            end
        end
        if_req = 0; d_req = 0;
        total++;
        if (order != "FDFD" || both != 0) begin
            bad++; $display("FAIL cont_order got=%s both=%0d want=FDFD both=0", order, both);
        end
        step(); step(); step(); step();
    endtask

    task automatic test_latency3();
        l3_d_req = 1; l3_d_we = 0; l3_d_addr = 10'h064;
        for (int c = 1; c <= 4; c++) begin
            step();
            total++;
            if (l3_d_ack !== 1'b0 || l3_busy !== 1'b1) begin
                bad++; $display("FAIL lat3_t%0d ack=%b busy=%b want 0 1", c, l3_d_ack, l3_busy);
            end
        end
        step();
        total++;
        if (l3_d_ack !== 1'b1 || l3_d_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL lat3_t5 ack=%b rdata=%h want 1 cafef00d", l3_d_ack, l3_d_rdata);
        end
        l3_d_req = 0;
        step();
        total++;
        if (l3_d_ack !== 1'b0 || l3_busy !== 1'b0) begin
            bad++; $display("FAIL lat3_t6 ack=%b busy=%b want 0 0", l3_d_ack, l3_busy);
        end
    endtask

    task automatic test_reset_mid_read();
        int acks;
        acks = 0;
        if_req = 1; if_addr = 10'h008;
        step();
        step();
        reset = 1; if_req = 0;
        step();
        total++;
        if ({if_ack, d_ack, d_fault, mem_MemWrite, busy} !== 5'b0 ||
            {if_rdata, d_rdata, mem_writeData, mem_address} !== 106'b0) begin
            bad++; $display("FAIL rst_mid ctrl=%b if_rdata=%h d_rdata=%h wd=%h addr=%h want all 0",
                            {if_ack, d_ack, d_fault, mem_MemWrite, busy}, if_rdata, d_rdata, mem_writeData, mem_address);
        end
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (if_ack || d_ack) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL rst_mid_noack got=%0d want=0", acks);
        end
        if_req = 1; if_addr = 10'h00C;
        step(); step(); step();
        total++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h0C0FFEE0) begin
            bad++; $display("FAIL rst_refetch ack=%b rdata=%h want 1 0c0ffee0", if_ack, if_rdata);
        end
        if_req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_protected_store();
        test_contention();
        test_latency3();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequencer and arbiter for the shared unified instruction/data memory of the multicycle CPU. Two requesters share the memory's single address/write port: the instruction-fetch unit and the load/store unit. The block arbitrates between them and drives the memory address and write strobe. It waits out the block-RAM read latency, returns registered read data with a one-cycle acknowledge, and rejects stores into the instruction region.

## Interface
Parameters:
- ADDRESS, 80, first byte address of the data region; addresses below it are instruction region.
- ADDR_W, 10, memory byte-address width.
- MEM_LATENCY, 1, cycles from address presented to valid mem_readData (1..3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  32  fetched word; valid while if_ack is high, held afterwards.
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse; load/store complete (or rejected).
- d_rdata  out  32  load data; valid while d_ack is high (loads only), held afterwards.
- d_fault  out  1  high with d_ack when a store targeted d_addr < ADDRESS.
- mem_address  out  ADDR_W  address to memory.
- mem_writeData  out  32  write data to memory.
- mem_MemWrite  out  1  memory write strobe.
- mem_readData  in  32  memory read word.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample the requests. Arbitration uses fairness register last_grant (reset value DATA).
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant, then update last_grant.
  - On grant, latch the address, operation and write data.
- Faulting store: a granted data store with d_addr < ADDRESS goes directly to RESP with d_fault=1. No memory access and no mem_MemWrite.
- ISSUE:
  - Drive mem_address and mem_writeData from the latched values.
  - For stores, mem_MemWrite=1 for exactly this cycle; then go to RESP.
  - For reads, go to WAIT with the latency counter loaded to MEM_LATENCY-1.
- WAIT:
  - mem_address remains driven.
  - When the counter reaches 0, register mem_readData into if_rdata or d_rdata according to the grant, then go to RESP.
- RESP:
  - Pulse the granted ack for one cycle (d_fault is valid in the same cycle).
  - Return to IDLE.
- Requester protocol:
  - A req still high in the cycle after its ack is treated as a new request.
  - Changing address or data while req is high and before ack is illegal; behaviour is unspecified.
- Reads of the instruction region by the data port are permitted (constant loads). Fetches are never checked.
- mem_address and mem_writeData hold their last values in IDLE and RESP. mem_MemWrite is 0 in every state except store ISSUE.

## Timing
- Request sampled in IDLE at cycle T0.
  - Load or fetch: ack at T0+2+MEM_LATENCY (T3 for latency 1).
  - Store: mem_MemWrite at T1, ack at T2.
  - Faulting store: ack and d_fault at T1.
- Back-to-back: next grant is possible in the cycle after RESP. Minimum request-to-request spacing: 3+MEM_LATENCY cycles for reads, 3 for stores.
- Reset values of all outputs are 0: if_ack, d_ack, d_fault, mem_MemWrite, busy, if_rdata, d_rdata, mem_address, mem_writeData. State resets to IDLE; last_grant resets to DATA, so the first tie goes to fetch.
- Reset mid-operation:
  - Abort the operation; no ack is issued.
  - mem_MemWrite is 0 from the cycle after reset is sampled.
  - A store strobe already issued is not undone.
- Requests arriving while busy are not acknowledged until serviced. Ties always alternate, so neither requester waits more than one foreign transaction.

## Test plan
- Single fetch: if_req=1, if_addr=0x000, memory word 0x20080005, MEM_LATENCY=1 -> if_ack pulses at T3 with if_rdata=0x20080005; busy high T1..T3.
- Store then load: d_we=1, d_addr=0x054, d_wdata=0xDEADBEEF -> mem_MemWrite high only at T1 with mem_address=0x054, d_ack at T2. Then load of 0x054 -> d_rdata=0xDEADBEEF with d_ack, d_fault=0.
- Protected store: d_we=1, d_addr=0x010 -> d_ack and d_fault at T1; mem_MemWrite never asserted; memory at 0x010 unchanged.
- Contention: if_req and d_req both held high from reset release -> grants alternate fetch, data, fetch, data; each ack pulses exactly once per transaction.
- Latency sweep: MEM_LATENCY=3 load -> d_ack at T5; data captured from the cycle when mem_readData becomes valid, not earlier.
- Reset mid-read: reset asserted in WAIT -> no ack, all outputs 0 the next cycle; a new fetch after release completes normally.
